mem_dump_reader: RTL and testbench
==================================

Name: mem_dump_reader

Overview:
- Bus-side reader that streams a contiguous address range out of the memory model as (address, data) beats on a valid/ready stream.
- Counterpart to the override/load path that writes an image into memory; this block reads memory back through the normal addr/dout port.
- Sits between the memory array's read port and a checker or logger; testbenches use it for end-of-test memory comparison instead of the monitor array.

Parameters:
- ADDR_WIDTH, 16, address width in bits; matches the CPU A bus.
- REG_WIDTH, 8, data width in bits; matches the CPU D bus.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- start_addr  in  ADDR_WIDTH  first address; latched when start is accepted.
- end_addr  in  ADDR_WIDTH  last address, inclusive; latched when start is accepted.
- busy  out  1  high from the cycle after start is accepted until DONE is left.
- done  out  1  one-cycle pulse when the final beat has been accepted.
- mem_re  out  1  read strobe to memory.
- mem_addr  out  ADDR_WIDTH  read address to memory.
- mem_rdata  in  REG_WIDTH  memory read data; valid the cycle after mem_re.
- out_valid  out  1  stream beat valid.
- out_ready  in  1  stream consumer ready.
- out_addr  out  ADDR_WIDTH  address of the current beat.
- out_data  out  REG_WIDTH  data of the current beat.

Behaviour:
- Reset, synchronous active-high, wins over all other inputs:
  - FSM goes to IDLE.
  - busy, done, mem_re, out_valid = 0.
  - mem_addr, out_addr, out_data = 0.
  - Internal cur and last registers = 0.
- FSM states: IDLE, ISSUE, CAPTURE, HOLD, DONE.
- IDLE:
  - start=1 latches cur=start_addr and last=end_addr, then goes to ISSUE.
  - start is ignored in every other state.
- ISSUE (1 cycle): mem_re=1, mem_addr=cur; go to CAPTURE.
- CAPTURE (1 cycle): register out_data=mem_rdata and out_addr=cur; set out_valid=1; go to HOLD.
- HOLD:
  - out_valid stays 1; out_addr and out_data stay stable until out_valid&&out_ready.
  - On the handshake: out_valid=0 next cycle. If cur==last, go to DONE; else cur=cur+1 modulo 2^ADDR_WIDTH and go to ISSUE.
- DONE (1 cycle): done=1, busy=0 next cycle; return to IDLE.
- mem_re is 0 outside ISSUE. mem_addr holds its last value.
- Latency:
  - First out_valid is 3 cycles after the start sample: IDLE→ISSUE→CAPTURE→out_valid registered.
  - With out_ready held high, throughput is 1 beat per 3 cycles.
- Range rules:
  - start_addr==end_addr gives exactly 1 beat.
  - end_addr<start_addr wraps through max address to 0; beat count = ((end−start) mod 2^ADDR_WIDTH)+1.
  - Full range (start=0, end=max) gives 2^ADDR_WIDTH beats.
- out_ready high while out_valid is low has no effect.
- Reset asserted mid-transfer aborts immediately: no done pulse, stream dropped.

Optional Feature:
- Macro: MEM_DUMP_CHECKSUM_EN.
- With the macro:
  - Extra output checksum, REG_WIDTH wide.
  - Cleared to 0 when start is accepted and on reset.
  - On each accepted beat: checksum = checksum + out_data, modulo 2^REG_WIDTH.
  - Final value is valid in the cycle done is high and holds until the next start.
- Without the macro: port and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package (PKG/pkg.v) holds:
  - the FSM state typedef (mem_dump_state_t, enum of the five states);
  - reuse of the existing ADDR_WIDTH/REG_WIDTH defines as parameter defaults.
- No sub-module. Checksum accumulator is inline under the ifdef.

Test Plan:
- Single beat:
  - Stimulus: mem[0x0010]=0xA5; start with start=end=0x0010; out_ready=1.
  - Expect: one beat (0x0010, 0xA5); out_valid first high 3 cycles after start; done pulse 1 cycle after handshake; busy low afterwards.
- Range of 8:
  - Stimulus: mem[0x0200..0x0207]=0x00..0x07; out_ready=1.
  - Expect: 8 beats in address order, one every 3 cycles, data matches; checksum=0x1C when the macro is on.
- Backpressure:
  - Stimulus: same range; out_ready low for 5 cycles on beat 3.
  - Expect: out_addr=0x0202 and out_data=0x02 stable throughout; mem_re not asserted during the stall; no beat lost or duplicated.
- Wrap:
  - Stimulus: start=0xFFFE, end=0x0001.
  - Expect: beats at 0xFFFE, 0xFFFF, 0x0000, 0x0001, then done.
- Start while busy, and reset mid-operation:
  - Stimulus: pulse start during HOLD of a 4-beat dump.
  - Expect: pulse ignored; 4 beats only.
  - Stimulus: assert reset during beat 2.
  - Expect: next cycle busy=0, out_valid=0, mem_re=0; no done pulse; a fresh start afterwards operates normally.

Source files
------------

// File: rtl/mem_dump_reader_pkg.sv
// ---------------------------------------------------------------------------
// mem_dump_reader_pkg
// Shared declarations for the memory dump reader:
//   - DEF_ADDR_WIDTH / DEF_REG_WIDTH : default bus widths (CPU A / D bus).
//   - mem_dump_state_t               : reader FSM state encoding.
// ---------------------------------------------------------------------------
package mem_dump_reader_pkg;

    localparam int DEF_ADDR_WIDTH = 16;
    localparam int DEF_REG_WIDTH  = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_CAPTURE,
        ST_HOLD,
        ST_DONE
    } mem_dump_state_t;

endpackage

// File: rtl/mem_dump_reader_if.sv
// ---------------------------------------------------------------------------
// mem_dump_reader_if
// Bundles the two buses of the dump reader:
//   memory read port : mem_re, mem_addr (reader -> memory), mem_rdata (back)
//   beat stream      : out_valid, out_addr, out_data (reader -> consumer),
//                      out_ready (back)
// Modports:
//   master : the dump reader
//   slave  : the memory model plus stream consumer
// ---------------------------------------------------------------------------
interface mem_dump_reader_if
    import mem_dump_reader_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int REG_WIDTH  = DEF_REG_WIDTH
);
    logic                  mem_re;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [REG_WIDTH-1:0]  mem_rdata;

    logic                  out_valid;
    logic                  out_ready;
    logic [ADDR_WIDTH-1:0] out_addr;
    logic [REG_WIDTH-1:0]  out_data;

    modport master (
        output mem_re, mem_addr, out_valid, out_addr, out_data,
        input  mem_rdata, out_ready
    );

    modport slave (
        input  mem_re, mem_addr, out_valid, out_addr, out_data,
        output mem_rdata, out_ready
    );
endinterface

// File: rtl/mem_dump_reader.sv
// ---------------------------------------------------------------------------
// mem_dump_reader
// Reads the inclusive address range [start_addr .. end_addr] (wrapping past
// the top address) out of a memory with one-cycle read latency and streams
// each location as an (address, data) beat on a valid/ready stream.
//
// Ports:
//   clk        : system clock, rising edge
//   reset      : synchronous, active-high
//   start      : dump request, only looked at while idle
//   start_addr : first address, captured with start
//   end_addr   : last address (inclusive), captured with start
//   busy       : dump in progress
//   done       : one-cycle pulse after the final beat is accepted
//   bus        : memory read port + beat stream (master side)
//   checksum   : running byte sum of accepted beats
//                (only when MEM_DUMP_CHECKSUM_EN is defined)
//
// Optional feature macro: MEM_DUMP_CHECKSUM_EN
// ---------------------------------------------------------------------------
module mem_dump_reader
    import mem_dump_reader_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int REG_WIDTH  = DEF_REG_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH-1:0] end_addr,
    output logic                  busy,
    output logic                  done,
    mem_dump_reader_if.master     bus
`ifdef MEM_DUMP_CHECKSUM_EN
    ,
    output logic [REG_WIDTH-1:0]  checksum
`endif
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

    mem_dump_state_t       state;
    logic [ADDR_WIDTH-1:0] cur;
    logic [ADDR_WIDTH-1:0] last;
    logic [ADDR_WIDTH-1:0] next_addr;

    // Natural overflow of the adder gives the wrap from the top address to 0.
    assign next_addr = cur + ADDR_ONE;

    // All outputs are registered: each one is set on the transition into the
    // state where it must be visible, so mem_re is high exactly during ISSUE
    // and the read data is sampled at the end of CAPTURE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            bus.mem_re    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.out_valid <= 1'b0;
            bus.out_addr  <= '0;
            bus.out_data  <= '0;
            cur           <= '0;
            last          <= '0;
`ifdef MEM_DUMP_CHECKSUM_EN
            checksum      <= '0;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values, regardless of statement order.
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        cur          <= start_addr;
                        last         <= end_addr;
                        busy         <= 1'b1;
                        bus.mem_re   <= 1'b1;
                        bus.mem_addr <= start_addr;
`ifdef MEM_DUMP_CHECKSUM_EN
                        checksum     <= '0;
`endif
                        state        <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    bus.mem_re <= 1'b0;
                    state      <= ST_CAPTURE;
                end

                ST_CAPTURE: begin
                    bus.out_data  <= bus.mem_rdata;
                    bus.out_addr  <= cur;
                    bus.out_valid <= 1'b1;
                    state         <= ST_HOLD;
                end

                ST_HOLD: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
`ifdef MEM_DUMP_CHECKSUM_EN
                        checksum      <= checksum + bus.out_data;
`endif
                        if (cur == last) begin
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            cur          <= next_addr;
                            bus.mem_re   <= 1'b1;
                            bus.mem_addr <= next_addr;
                            state        <= ST_ISSUE;
                        end
                    end
                end

                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_dump_reader.sv
// ---------------------------------------------------------------------------
// tb_mem_dump_reader
// Self-checking bench for mem_dump_reader. A byte-array memory with one-cycle
// read latency serves the read port. Each dump is modelled as a queue of the
// expected (address, data) beats, plus the timing rules: read strobe one cycle
// after start or after a handshake, beat valid three cycles after that point,
// done one cycle after the last handshake. A single negedge process compares
// every output against that model on every cycle.
// ---------------------------------------------------------------------------
module tb_mem_dump_reader;
    import mem_dump_reader_pkg::*;

    localparam int AW   = DEF_ADDR_WIDTH;
    localparam int RW   = DEF_REG_WIDTH;
    localparam int SPAN = 1 << AW;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [RW-1:0] data;
    } beat_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] start_addr;
    logic [AW-1:0] end_addr;
    logic          busy;
    logic          done;
`ifdef MEM_DUMP_CHECKSUM_EN
    logic [RW-1:0] checksum;
`endif

    mem_dump_reader_if #(.ADDR_WIDTH(AW), .REG_WIDTH(RW)) bus ();

    mem_dump_reader #(.ADDR_WIDTH(AW), .REG_WIDTH(RW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .start_addr (start_addr),
        .end_addr   (end_addr),
        .busy       (busy),
        .done       (done),
        .bus        (bus)
`ifdef MEM_DUMP_CHECKSUM_EN
        ,
        .checksum   (checksum)
`endif
    );

    always #5 clk = ~clk;

    // Memory model: data valid the cycle after the strobe, garbage otherwise.
    logic [RW-1:0] mem [0:SPAN-1];
    always @(posedge clk)
        bus.mem_rdata <= bus.mem_re ? mem[bus.mem_addr] : RW'($urandom);

    // ---------------- bookkeeping ----------------
    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model state ----------------
    beat_t         exp_q[$];
    bit            active    = 1'b0;
    bit            valid_exp = 1'b0;
    int            start_cyc   = -100;
    int            last_hs_cyc = -100;
    int            first_valid_cyc;
    int            done_cyc;
    int            beats;
    int            dump_len;
    int            stall_seen;
    logic [RW-1:0] csum_obs;
    logic [AW-1:0] first_addr, last_addr;
    logic [RW-1:0] first_data;
    bit            exp_re, exp_done, exp_busy;

    // ---------------- stream consumer ----------------
    int ready_mode = 3;   // 0: always ready, 1: random, 2: stall beat 3 for 5 cycles, 3: never ready
    int stall_cnt  = 0;
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: bus.out_ready = 1'b1;
            1: bus.out_ready = 1'($urandom_range(0, 1));
            2: begin
                if (bus.out_valid && beats == 2 && stall_cnt < 5) begin
                    bus.out_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    bus.out_ready = 1'b1;
                end
            end
            default: bus.out_ready = 1'b0;
        endcase
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            active    = 1'b0;
            valid_exp = 1'b0;
        end else begin
            exp_re = active && exp_q.size() > 0 &&
                     (cyc == start_cyc + 1 || cyc == last_hs_cyc + 1);
            if (!valid_exp && active && exp_q.size() > 0 &&
                (cyc == start_cyc + 3 || cyc == last_hs_cyc + 3)) begin
                valid_exp = 1'b1;
                if (beats == 0) first_valid_cyc = cyc;
            end
            exp_done = active && exp_q.size() == 0 && cyc == last_hs_cyc + 1;
            exp_busy = active && cyc > start_cyc;

            check("mem_re", bus.mem_re, exp_re);
            if (exp_re && bus.mem_re) check("mem_addr", bus.mem_addr, exp_q[0].addr);
            check("out_valid", bus.out_valid, valid_exp);
            if (valid_exp && bus.out_valid) begin
                check("out_addr", bus.out_addr, exp_q[0].addr);
                check("out_data", bus.out_data, exp_q[0].data);
            end
            check("done", done, exp_done);
            check("busy", busy, exp_busy);
`ifdef MEM_DUMP_CHECKSUM_EN
            if (active && cyc == start_cyc + 1) check("checksum_clear", checksum, 0);
            if (exp_done) check("checksum_final", checksum, csum_obs);
`endif
            if (valid_exp && bus.out_valid && bus.out_ready) begin
                csum_obs = csum_obs + bus.out_data;
                if (beats == 0) begin
                    first_addr = bus.out_addr;
                    first_data = bus.out_data;
                end
                last_addr   = bus.out_addr;
                void'(exp_q.pop_front());
                beats++;
                last_hs_cyc = cyc;
                valid_exp   = 1'b0;
            end else if (valid_exp && bus.out_valid) begin
                if (bus.out_addr == AW'(16'h0202) && bus.out_data == RW'(8'h02)) stall_seen++;
            end
            if (exp_done) begin
                active   = 1'b0;
                done_cyc = cyc;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Called just after a rising edge; drives a one-cycle start and loads the model.
    task automatic begin_dump(input logic [AW-1:0] sa, input logic [AW-1:0] ea);
        logic [AW-1:0] a;
        int n;
        n = ((int'(ea) - int'(sa) + SPAN) % SPAN) + 1;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            a = AW'((int'(sa) + i) % SPAN);
            exp_q.push_back({a, mem[a]});
        end
        beats       = 0;
        csum_obs    = '0;
        last_hs_cyc = -100;
        valid_exp   = 1'b0;
        start_cyc   = cyc;
        dump_len    = n;
        active      = 1'b1;
        start_addr  = sa;
        end_addr    = ea;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start      = 1'b0;
        start_addr = AW'($urandom);
        end_addr   = AW'($urandom);
    endtask

    task automatic wait_done(input int budget, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check({name, "_done_seen"}, 32'(seen), 1);
        check({name, "_beat_count"}, beats, dump_len);
        @(posedge clk);
        #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bit seen;
        logic [AW-1:0] sa;
        int len;

        reset      = 1'b1;
        start      = 1'b0;
        start_addr = '0;
        end_addr   = '0;
        for (int i = 0; i < SPAN; i++) mem[i] = RW'($urandom);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_mem_re", bus.mem_re, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_addr", bus.out_addr, 0);
        check("rst_out_data", bus.out_data, 0);
        @(posedge clk);
        #1;
        reset      = 1'b0;
        ready_mode = 0;
        @(posedge clk);
        #1;

        // Single beat.
        mem[16'h0010] = 8'hA5;
        begin_dump(16'h0010, 16'h0010);
        wait_done(20, "single");
        check("single_addr", first_addr, 32'h0010);
        check("single_data", first_data, 32'hA5);
        check("single_valid_latency", first_valid_cyc - start_cyc, 3);
        check("single_done_latency", done_cyc - start_cyc, 4);
        @(negedge clk);
        check("single_busy_after", busy, 0);
        @(posedge clk);
        #1;

        // Range of 8 at full throughput.
        for (int i = 0; i < 8; i++) mem[16'h0200 + i] = RW'(i);
        begin_dump(16'h0200, 16'h0207);
        wait_done(60, "range8");
        check("range8_done_latency", done_cyc - start_cyc, 25);
        check("range8_last_addr", last_addr, 32'h0207);
        check("range8_sum", csum_obs, 32'h1C);

        // Backpressure on beat 3.
        ready_mode = 2;
        stall_cnt  = 0;
        stall_seen = 0;
        begin_dump(16'h0200, 16'h0207);
        wait_done(80, "stall");
        check("stall_cycles_held", stall_seen, 5);
        check("stall_done_latency", done_cyc - start_cyc, 30);
        ready_mode = 0;

        // Wrap through the top address.
        begin_dump(16'hFFFE, 16'h0001);
        wait_done(40, "wrap");
        check("wrap_first_addr", first_addr, 32'hFFFE);
        check("wrap_last_addr", last_addr, 32'h0001);
        check("wrap_beats", beats, 4);

        // Start pulse during HOLD is ignored.
        ready_mode = 3;
        @(posedge clk);
        #1;
        begin_dump(16'h0300, 16'h0303);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        check("busy_start_valid_seen", 32'(seen), 1);
        @(posedge clk);
        #1;
        start      = 1'b1;
        start_addr = 16'h0050;
        end_addr   = 16'h0060;
        @(posedge clk);
        #1;
        start      = 1'b0;
        ready_mode = 0;
        wait_done(60, "busy_start");
        check("busy_start_beats", beats, 4);

        // Reset during beat 2, then a fresh dump.
        begin_dump(16'h0200, 16'h0207);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (beats == 1 && bus.out_valid) seen = 1'b1;
        end
        check("reset_beat2_seen", 32'(seen), 1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_out_valid", bus.out_valid, 0);
        check("abort_mem_re", bus.mem_re, 0);
        check("abort_done", done, 0);
        repeat (10) @(posedge clk);
        #1;
        begin_dump(16'h0010, 16'h0010);
        wait_done(20, "after_reset");
        check("after_reset_data", first_data, 32'hA5);

        // Randomised ranges with random backpressure.
        ready_mode = 1;
        for (int k = 0; k < 10; k++) begin
            sa  = AW'($urandom);
            len = int'($urandom_range(0, 12));
            begin_dump(sa, sa + AW'(len));
            wait_done(40 * (len + 1) + 20, "random");
        end
        ready_mode = 0;
        repeat (3) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
